// File: rtl/lstm_pkg.sv
// Shared constants, state type and slot addressing
// for the LSTM inference sequencer.
package lstm_pkg;

    localparam int NUM_PARAMS    = 6002;
    localparam int BW            = 32;
    localparam int ENC           = 27;
    localparam int SEQ_LENGTH    = 4;
    localparam int SETTLE_CYCLES = 8;
    localparam int AW            = $clog2(NUM_PARAMS);

    localparam logic [BW-1:0] ONE_VAL = 32'h0001_0000;

    localparam int SLOT_W = BW * ENC;
    localparam int WORD_W = SLOT_W * SEQ_LENGTH;
    localparam int SCW    = $clog2(SEQ_LENGTH + 1);
    localparam int CCW    = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_COLLECT,
        ST_SETTLE,
        ST_OUTPUT
    } ctrl_state_t;

    function automatic int slot_base(input int t, input int e);
        return (t * ENC + e) * BW;
    endfunction

endpackage

// File: rtl/lstm_onehot_slot.sv
// One-hot encoder for a single window slot:
// character index -> ENC words, ONE_VAL at the index.
module lstm_onehot_slot
    import lstm_pkg::*;
(
    input  logic [4:0]        in_char,
    output logic [SLOT_W-1:0] slot_vec,
    output logic              out_of_range
);

    // Indices past the alphabet leave the slot all zeros.
    always_comb begin
        slot_vec     = '0;
        out_of_range = (in_char >= 5'(ENC));
        for (int e = 0; e < ENC; e++) begin
            if (in_char == 5'(e)) begin
                slot_vec[slot_base(0, e) +: BW] = ONE_VAL;
            end
        end
    end

endmodule

// File: rtl/lstm_infer_ctrl.sv
// Parameter loader, input window builder and
// prediction capture for the LSTM model.
module lstm_infer_ctrl
    import lstm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              p_valid,
    input  logic [BW-1:0]     p_data,
    output logic              p_ready,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [AW-1:0]     mem_addr,
    output logic [BW-1:0]     mem_dina,
    output logic              load_done,
    input  logic              in_valid,
    input  logic [4:0]        in_char,
    output logic              in_ready,
    output logic [WORD_W-1:0] word_out,
    input  logic [5:0]        pred_char_in,
    output logic              out_valid,
    output logic [5:0]        out_char,
    input  logic              out_ready,
    output logic              bad_char
);

    ctrl_state_t       state;
    logic [AW-1:0]     addr_cnt;
    logic [SCW-1:0]    slot_cnt;
    logic [CCW-1:0]    settle_cnt;
    logic [SLOT_W-1:0] slot_vec;
    logic              slot_bad;

    lstm_onehot_slot u_enc (
        .in_char      (in_char),
        .slot_vec     (slot_vec),
        .out_of_range (slot_bad)
    );

    // Sequencer; every output is a register so the
    // write strobes never see p_valid combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            p_ready    <= 1'b0;
            in_ready   <= 1'b0;
            mem_ena    <= 1'b0;
            mem_wea    <= 1'b0;
            mem_addr   <= '0;
            mem_dina   <= '0;
            load_done  <= 1'b0;
            word_out   <= '0;
            out_valid  <= 1'b0;
            out_char   <= '0;
            bad_char   <= 1'b0;
            addr_cnt   <= '0;
            slot_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            mem_ena <= 1'b0;
            mem_wea <= 1'b0;
            if (start_load &&
                (state == ST_IDLE || state == ST_COLLECT)) begin
                state     <= ST_LOAD;
                p_ready   <= 1'b1;
                in_ready  <= 1'b0;
                addr_cnt  <= '0;
                slot_cnt  <= '0;
                word_out  <= '0;
                load_done <= 1'b0;
                bad_char  <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                    end
                    ST_LOAD: begin
                        if (p_valid && p_ready) begin
                            mem_ena  <= 1'b1;
                            mem_wea  <= 1'b1;
                            mem_addr <= addr_cnt;
                            mem_dina <= p_data;
                            addr_cnt <= addr_cnt + AW'(1);
                            if (addr_cnt == AW'(NUM_PARAMS - 1)) begin
                                state   <= ST_FLUSH;
                                p_ready <= 1'b0;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        state     <= ST_COLLECT;
                        load_done <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                    ST_COLLECT: begin
                        if (in_valid && in_ready) begin
                            for (int t = 0; t < SEQ_LENGTH; t++) begin
                                if (slot_cnt == SCW'(t)) begin
                                    word_out[slot_base(t, 0) +: SLOT_W]
                                        <= slot_vec;
                                end
                            end
                            slot_cnt <= slot_cnt + SCW'(1);
                            if (slot_bad) begin
                                bad_char <= 1'b1;
                            end
                            if (slot_cnt == SCW'(SEQ_LENGTH - 1)) begin
                                state      <= ST_SETTLE;
                                in_ready   <= 1'b0;
                                settle_cnt <= CCW'(SETTLE_CYCLES);
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == CCW'(1)) begin
                            out_char   <= pred_char_in;
                            out_valid  <= 1'b1;
                            settle_cnt <= '0;
                            state      <= ST_OUTPUT;
                        end else begin
                            settle_cnt <= settle_cnt - CCW'(1);
                        end
                    end
                    ST_OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            word_out  <= '0;
                            slot_cnt  <= '0;
                            in_ready  <= 1'b1;
                            state     <= ST_COLLECT;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lstm_infer_ctrl.sv
// Directed bench for lstm_infer_ctrl with a
// phase-level reference model checked every cycle.
module tb_lstm_infer_ctrl;
    import lstm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_load;
    logic              p_valid;
    logic [BW-1:0]     p_data;
    logic              p_ready;
    logic              mem_ena;
    logic              mem_wea;
    logic [AW-1:0]     mem_addr;
    logic [BW-1:0]     mem_dina;
    logic              load_done;
    logic              in_valid;
    logic [4:0]        in_char;
    logic              in_ready;
    logic [WORD_W-1:0] word_out;
    logic [5:0]        pred_char_in;
    logic              out_valid;
    logic [5:0]        out_char;
    logic              out_ready;
    logic              bad_char;

    int tests = 0;
    int fails = 0;
    int ena_count = 0;

    lstm_infer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .p_valid      (p_valid),
        .p_data       (p_data),
        .p_ready      (p_ready),
        .mem_ena      (mem_ena),
        .mem_wea      (mem_wea),
        .mem_addr     (mem_addr),
        .mem_dina     (mem_dina),
        .load_done    (load_done),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_ready     (in_ready),
        .word_out     (word_out),
        .pred_char_in (pred_char_in),
        .out_valid    (out_valid),
        .out_char     (out_char),
        .out_ready    (out_ready),
        .bad_char     (bad_char)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: protocol phases, not RTL states.
    typedef enum {P_IDLE, P_LOAD, P_FLUSH,
                  P_COLLECT, P_SETTLE, P_OUT} phase_t;

    localparam int LAT_OUT = SETTLE_CYCLES + 1;

    phase_t            ph = P_IDLE;
    int                wr_count = 0;
    int                dly = 0;
    bit                pend = 0;
    int                pa = 0;
    logic [BW-1:0]     pd = '0;
    bit                m_done = 0;
    bit                m_bad = 0;
    logic [5:0]        exp_char = '0;
    int                chars[$];
    logic [WORD_W-1:0] exp_w;

    // Compare DUT against the model, then advance the
    // model with the handshakes the next edge will take.
    always @(negedge clk) begin
        if (!rst_n) begin
            ph = P_IDLE;
            wr_count = 0;
            dly = 0;
            pend = 0;
            m_done = 0;
            m_bad = 0;
            chars.delete();
            chk("rst_addr", mem_addr, 0);
            chk("rst_dina", mem_dina, 0);
            chk("rst_out_char", out_char, 0);
        end
        chk("mem_ena", mem_ena, pend);
        chk("mem_wea", mem_wea, pend);
        if (pend) begin
            chk("mem_addr", mem_addr, pa);
            chk("mem_dina", mem_dina, pd);
        end
        chk("p_ready", p_ready, ph == P_LOAD);
        chk("in_ready", in_ready, ph == P_COLLECT);
        chk("load_done", load_done, m_done);
        chk("bad_char", bad_char, m_bad);
        chk("out_valid", out_valid, ph == P_OUT);
        if (ph == P_OUT) chk("out_char", out_char, exp_char);
        exp_w = '0;
        foreach (chars[t]) begin
            if (chars[t] < ENC)
                exp_w[(t * ENC + chars[t]) * BW +: BW] = ONE_VAL;
        end
        tests++;
        if (word_out !== exp_w) begin
            fails++;
            for (int i = 0; i < WORD_W / BW; i++) begin
                if (word_out[i*BW +: BW] !== exp_w[i*BW +: BW]) begin
                    $display("FAIL word_out word %0d: got %0h expected %0h",
                             i, word_out[i*BW +: BW], exp_w[i*BW +: BW]);
                    break;
                end
            end
        end
        if (mem_ena === 1'b1) ena_count++;
        pend = 0;
        if (rst_n) begin
            if (ph == P_FLUSH || ph == P_SETTLE) begin
                if (dly > 0) dly--;
                if (dly == 0) begin
                    if (ph == P_FLUSH) begin
                        ph = P_COLLECT;
                        m_done = 1;
                    end else begin
                        ph = P_OUT;
                        exp_char = pred_char_in;
                    end
                end
            end
            if (start_load && (ph == P_IDLE || ph == P_COLLECT)) begin
                ph = P_LOAD;
                wr_count = 0;
                m_done = 0;
                m_bad = 0;
                chars.delete();
            end else if (ph == P_LOAD && p_valid && p_ready) begin
                pend = 1;
                pa = wr_count;
                pd = p_data;
                wr_count++;
                if (wr_count == NUM_PARAMS) begin
                    ph = P_FLUSH;
                    dly = 1;
                end
            end else if (ph == P_COLLECT && in_valid && in_ready) begin
                chars.push_back(int'(in_char));
                if (int'(in_char) >= ENC) m_bad = 1;
                if (chars.size() == SEQ_LENGTH) begin
                    ph = P_SETTLE;
                    dly = LAT_OUT - 1;
                end
            end else if (ph == P_OUT && out_valid && out_ready) begin
                ph = P_COLLECT;
                chars.delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        step();
        start_load = 1'b0;
    endtask

    task automatic load_words(input bit rnd, input int first,
                              input int stop_at);
        int sent = first;
        int guard = 0;
        p_data = BW'(sent);
        p_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (sent < stop_at && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (p_valid && p_ready) sent++;
            step();
            p_data = BW'(sent);
            if (sent >= stop_at) p_valid = 1'b0;
            else p_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        p_valid = 1'b0;
        chk("load_words_done", sent, stop_at);
    endtask

    task automatic send_char(input int c);
        int g = 0;
        bit ok = 0;
        in_valid = 1'b1;
        in_char = 5'(c);
        while (!ok && g < 200) begin
            @(negedge clk);
            g++;
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("char_accept", ok, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b1;
        start_load = 1'b0;
        p_valid = 1'b0;
        p_data = '0;
        in_valid = 1'b0;
        in_char = '0;
        pred_char_in = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_p_ready", p_ready, 0);
        chk("reset_load_done", load_done, 0);
        chk("reset_word_bits", $countones(word_out), 0);
        chk("reset_out_valid", out_valid, 0);
        rst_n = 1'b1;
        step();

        // Back-to-back load, p_data = index.
        ena_count = 0;
        pulse_start();
        load_words(0, 0, NUM_PARAMS);
        @(negedge clk);
        chk("final_p_ready", p_ready, 0);
        chk("final_ena", mem_ena, 1);
        chk("final_addr", mem_addr, 6001);
        chk("final_dina", mem_dina, 6001);
        chk("done_k1", load_done, 0);
        @(negedge clk);
        chk("done_k2", load_done, 1);
        chk("ena_after_flush", mem_ena, 0);
        chk("collect_ready", in_ready, 1);
        step();
        chk("write_count", ena_count, 6002);

        // Window 3,0,26,7 with consumer ready.
        pred_char_in = 6'd12;
        out_ready = 1'b1;
        send_char(3);
        send_char(0);
        send_char(26);
        send_char(7);
        wait_out(lat);
        chk("latency", lat, 9);
        chk("pred_12", out_char, 12);
        chk("slot0_c3", word_out[96 +: 32], 32'h0001_0000);
        chk("slot1_c0", word_out[864 +: 32], 32'h0001_0000);
        chk("slot2_c26", word_out[2560 +: 32], 32'h0001_0000);
        chk("slot3_c7", word_out[2816 +: 32], 32'h0001_0000);
        chk("window_bits", $countones(word_out), 4);
        step();
        @(negedge clk);
        chk("cleared_bits", $countones(word_out), 0);
        chk("back_collect", in_ready, 1);

        // Consumer stalls five cycles.
        step();
        out_ready = 1'b0;
        pred_char_in = 6'd33;
        send_char(1);
        send_char(2);
        send_char(3);
        send_char(4);
        wait_out(lat);
        chk("latency_stall", lat, 9);
        step();
        pred_char_in = 6'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_char", out_char, 33);
            chk("hold_in_ready", in_ready, 0);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_bits", $countones(word_out), 0);
        chk("release_ready", in_ready, 1);

        // Out-of-range character.
        step();
        pred_char_in = 6'd5;
        send_char(30);
        @(negedge clk);
        chk("bad_set", bad_char, 1);
        chk("bad_slot_zero", $countones(word_out[863:0]), 0);
        step();
        send_char(5);
        send_char(6);
        send_char(9);
        wait_out(lat);
        chk("bad_window_bits", $countones(word_out), 3);
        chk("bad_pred", out_char, 5);
        step();
        send_char(1);
        send_char(2);
        @(negedge clk);
        chk("bad_sticky", bad_char, 1);
        step();

        // Reload from COLLECT with random p_valid.
        pulse_start();
        @(negedge clk);
        chk("reload_bad_clear", bad_char, 0);
        chk("reload_bits", $countones(word_out), 0);
        chk("reload_p_ready", p_ready, 1);
        chk("reload_done_clr", load_done, 0);
        step();
        ena_count = 0;
        load_words(1, 0, NUM_PARAMS);
        @(negedge clk);
        @(negedge clk);
        chk("rand_done", load_done, 1);
        step();
        chk("rand_write_count", ena_count, 6002);

        // Reset in the middle of a load.
        pulse_start();
        load_words(0, 0, 101);
        rst_n = 1'b0;
        #1;
        chk("abort_ena", mem_ena, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_p_ready", p_ready, 0);
        chk("abort_done", load_done, 0);
        chk("abort_bits", $countones(word_out), 0);
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        load_words(0, 0, 1);
        @(negedge clk);
        chk("restart_ena", mem_ena, 1);
        chk("restart_addr", mem_addr, 0);
        step();
        load_words(0, 1, NUM_PARAMS);
        @(negedge clk);
        @(negedge clk);
        chk("restart_done", load_done, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
